// File: rtl/tlight_monitor.sv
// tlight_package: light command encoding shared by controller and monitor.
//   RED=00, YELLOW=01, GREEN=10; 11 is an invalid command.
//
// tlight_monitor: passive run-time safety checker for the traffic-light
// control interface. Samples ns/we every clock and flags conflicts, illegal
// colour sequences, dwell-time violations and all-red stalls.
//   clock        in   system clock (1 s period)
//   reset_n      in   asynchronous active-low reset
//   ns, we       in   light commands (tlight_control_t)
//   clear        in   synchronous clear of the sticky error flags
//   err_conflict out  sticky: both directions non-RED in one sample
//   err_sequence out  sticky: illegal transition or invalid encoding
//   err_timing   out  sticky: dwell outside its [MIN, MAX] window
//   err_stall    out  sticky: all-red longer than ALLRED_MAX
//   err_any      out  OR of the four sticky flags
//   phase_count  out  completed stop phases (wraps at 2^16)
package tlight_package;
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } tlight_control_t;
endpackage

module tlight_monitor
  import tlight_package::*;
#(
  parameter int unsigned GREEN_MIN  = 14,
  parameter int unsigned GREEN_MAX  = 16,
  parameter int unsigned YELLOW_MIN = 1,
  parameter int unsigned YELLOW_MAX = 4,
  parameter int unsigned ALLRED_MAX = 4,
  parameter int unsigned CNT_W      = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  tlight_control_t ns,
  input  tlight_control_t we,
  input  logic            clear,
  output logic            err_conflict,
  output logic            err_sequence,
  output logic            err_timing,
  output logic            err_stall,
  output logic            err_any,
  output logic [15:0]     phase_count
);

  typedef enum logic [1:0] {
    D_RED   = 2'b00,
    D_READY = 2'b01,
    D_GREEN = 2'b10,
    D_STOP  = 2'b11
  } dir_state_t;

  typedef struct packed {
    dir_state_t       state;
    logic [CNT_W-1:0] dwell;
    logic             seq;
    logic             tim;
    logic             phase;
  } step_t;

  localparam logic [CNT_W-1:0] L_SAT  = '1;
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] L_GOVR = CNT_W'(GREEN_MAX + 1);
  localparam logic [CNT_W-1:0] L_YMIN = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] L_YOVR = CNT_W'(YELLOW_MAX + 1);
  localparam logic [CNT_W-1:0] L_AOVR = CNT_W'(ALLRED_MAX + 1);

  dir_state_t       r_ns_state, r_we_state;
  logic [CNT_W-1:0] r_ns_dwell, r_we_dwell;
  logic [CNT_W-1:0] r_allred;
  logic             r_err_conflict, r_err_sequence, r_err_timing, r_err_stall;
  logic [15:0]      r_phase_count;

  step_t            w_ns_step, w_we_step;
  logic [CNT_W-1:0] w_allred_next;
  logic             w_conflict, w_stall;

  // One sample of a direction checker. Exit checks use the dwell accumulated
  // before this sample; overrun checks use the dwell including this sample,
  // matched exactly so each residence reports at most once.
  function automatic step_t dir_step(input dir_state_t st,
                                     input logic [CNT_W-1:0] dw,
                                     input tlight_control_t col);
    step_t s;
    s.state = st;
    s.dwell = (dw == L_SAT) ? dw : dw + 1'b1;
    s.seq   = 1'b0;
    s.tim   = 1'b0;
    s.phase = 1'b0;
    case (st)
      D_RED: begin
        case (col)
          RED:     s.state = D_RED;
          YELLOW:  begin s.state = D_READY; s.dwell = L_ONE; end
          default: s.seq = 1'b1;
        endcase
      end
      D_READY: begin
        case (col)
          YELLOW:  s.tim = (s.dwell == L_YOVR);
          GREEN:   begin s.state = D_GREEN; s.dwell = L_ONE; s.tim = (dw < L_YMIN); end
          default: s.seq = 1'b1;
        endcase
      end
      D_GREEN: begin
        case (col)
          GREEN:   s.tim = (s.dwell == L_GOVR);
          YELLOW:  begin s.state = D_STOP; s.dwell = L_ONE; s.tim = (dw < L_GMIN); end
          default: s.seq = 1'b1;
        endcase
      end
      default: begin // D_STOP
        case (col)
          YELLOW:  s.tim = (s.dwell == L_YOVR);
          RED:     begin
                     s.state = D_RED; s.dwell = L_ONE;
                     s.tim = (dw < L_YMIN); s.phase = 1'b1;
                   end
          default: s.seq = 1'b1;
        endcase
      end
    endcase
    // Illegal input: resync on the observed colour, restart the dwell and
    // suppress any timing verdict for the abandoned residence.
    if (s.seq) begin
      s.dwell = L_ONE;
      s.tim   = 1'b0;
      case (col)
        GREEN:   s.state = D_GREEN;
        YELLOW:  s.state = D_STOP;
        default: s.state = D_RED;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    w_ns_step     = dir_step(r_ns_state, r_ns_dwell, ns);
    w_we_step     = dir_step(r_we_state, r_we_dwell, we);
    w_conflict    = (ns != RED) && (we != RED);
    w_allred_next = '0;
    if ((ns == RED) && (we == RED))
      w_allred_next = (r_allred == L_SAT) ? r_allred : r_allred + 1'b1;
    w_stall       = (w_allred_next == L_AOVR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ns_state     <= D_RED;
      r_we_state     <= D_RED;
      r_ns_dwell     <= '0;
      r_we_dwell     <= '0;
      r_allred       <= '0;
      r_err_conflict <= 1'b0;
      r_err_sequence <= 1'b0;
      r_err_timing   <= 1'b0;
      r_err_stall    <= 1'b0;
      r_phase_count  <= '0;
    end else begin
      r_ns_state     <= w_ns_step.state;
      r_we_state     <= w_we_step.state;
      r_ns_dwell     <= w_ns_step.dwell;
      r_we_dwell     <= w_we_step.dwell;
      r_allred       <= w_allred_next;
      // New violations win over a simultaneous clear.
      r_err_conflict <= (r_err_conflict & ~clear) | w_conflict;
      r_err_sequence <= (r_err_sequence & ~clear) | w_ns_step.seq | w_we_step.seq;
      r_err_timing   <= (r_err_timing & ~clear) | w_ns_step.tim | w_we_step.tim;
      r_err_stall    <= (r_err_stall & ~clear) | w_stall;
      r_phase_count  <= r_phase_count + 16'(w_ns_step.phase) + 16'(w_we_step.phase);
    end
  end

  assign err_conflict = r_err_conflict;
  assign err_sequence = r_err_sequence;
  assign err_timing   = r_err_timing;
  assign err_stall    = r_err_stall;
  assign err_any      = r_err_conflict | r_err_sequence | r_err_timing | r_err_stall;
  assign phase_count  = r_phase_count;

endmodule

// File: tb/tb_tlight_monitor.sv
`timescale 1ns/1ps
module tb_tlight_monitor;
  import tlight_package::*;

  localparam int GMIN = 14, GMAX = 16, YMIN = 1, YMAX = 4, AMAX = 4, SAT = 31;

  logic            clock = 1'b0;
  logic            reset_n;
  tlight_control_t ns_i, we_i;
  logic            clear_i;
  logic            err_conflict, err_sequence, err_timing, err_stall, err_any;
  logic [15:0]     phase_count;

  int n_checks = 0;
  int n_err    = 0;

  tlight_monitor #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_MIN(YMIN),
    .YELLOW_MAX(YMAX), .ALLRED_MAX(AMAX), .CNT_W(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ns(ns_i), .we(we_i), .clear(clear_i),
    .err_conflict(err_conflict), .err_sequence(err_sequence),
    .err_timing(err_timing), .err_stall(err_stall), .err_any(err_any),
    .phase_count(phase_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: colours 0=red 1=yellow 2=green 3=invalid. Each direction
  // remembers the colour of its current residence, whether that yellow came
  // after green, and how long it has lasted.
  int m_col[2];
  bit m_fromg[2];
  int m_dw[2];
  int m_ar;
  bit m_conf, m_seq, m_tim, m_stall;
  int m_phase;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin m_col[d] = 0; m_fromg[d] = 0; m_dw[d] = 0; end
    m_ar = 0; m_conf = 0; m_seq = 0; m_tim = 0; m_stall = 0; m_phase = 0;
  endtask

  task automatic model_dir(input int d, input int c, output bit seq, output bit tim, output bit ph);
    bit legal;
    seq = 0; tim = 0; ph = 0;
    legal = (m_col[d] == 0 && c == 1) || (m_col[d] == 1 && !m_fromg[d] && c == 2) ||
            (m_col[d] == 2 && c == 1) || (m_col[d] == 1 && m_fromg[d] && c == 0);
    if (c == m_col[d]) begin
      m_dw[d] = (m_dw[d] < SAT) ? m_dw[d] + 1 : SAT;
      if (m_col[d] == 2 && m_dw[d] == GMAX + 1) tim = 1;
      if (m_col[d] == 1 && m_dw[d] == YMAX + 1) tim = 1;
    end else if (legal) begin
      if (m_col[d] == 2 && m_dw[d] < GMIN) tim = 1;
      if (m_col[d] == 1 && m_dw[d] < YMIN) tim = 1;
      if (m_col[d] == 1 && m_fromg[d] && c == 0) ph = 1;
      m_fromg[d] = (m_col[d] == 2);
      m_col[d] = c; m_dw[d] = 1;
    end else begin
      seq = 1;
      m_col[d] = (c == 3) ? 0 : c;
      m_fromg[d] = (c == 1);
      m_dw[d] = 1;
    end
  endtask

  task automatic model_step(input int n, input int w, input bit clr);
    bit s0, t0, p0, s1, t1, p1, conf, stall;
    model_dir(0, n, s0, t0, p0);
    model_dir(1, w, s1, t1, p1);
    conf = (n != 0) && (w != 0);
    if (n == 0 && w == 0) m_ar = (m_ar < SAT) ? m_ar + 1 : SAT; else m_ar = 0;
    stall = (m_ar == AMAX + 1);
    m_conf  = (m_conf  && !clr) || conf;
    m_seq   = (m_seq   && !clr) || s0 || s1;
    m_tim   = (m_tim   && !clr) || t0 || t1;
    m_stall = (m_stall && !clr) || stall;
    m_phase = (m_phase + int'(p0) + int'(p1)) % 65536;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".conflict"}, 16'(err_conflict), 16'(m_conf));
    check({tag, ".sequence"}, 16'(err_sequence), 16'(m_seq));
    check({tag, ".timing"},   16'(err_timing),   16'(m_tim));
    check({tag, ".stall"},    16'(err_stall),    16'(m_stall));
    check({tag, ".any"},      16'(err_any),      16'(m_conf | m_seq | m_tim | m_stall));
    check({tag, ".phase"},    phase_count,       16'(m_phase));
  endtask

  task automatic cyc(input string tag, input int n, input int w, input bit clr);
    ns_i = tlight_control_t'(2'(n));
    we_i = tlight_control_t'(2'(w));
    clear_i = clr;
    model_step(n, w, clr);
    @(posedge clock); #1;
    check_model(tag);
  endtask

  task automatic run(input string tag, input int k, input int n, input int w);
    repeat (k) cyc(tag, n, w, 1'b0);
  endtask

  task automatic legal_cycle(input string tag);
    run(tag, 1, 0, 0);
    run(tag, 3, 0, 1);
    run(tag, 15, 0, 2);
    run(tag, 1, 0, 1);
    run(tag, 3, 1, 0);
    run(tag, 15, 2, 0);
    run(tag, 1, 1, 0);
    run(tag, 1, 0, 0);
  endtask

  // Randomised sample: occasional glitch to any encoding, occasional clear.
  task automatic rstep(input int n, input int w);
    int nn = n, ww = w;
    if ($urandom_range(0, 29) == 0) nn = int'($urandom_range(0, 3));
    if ($urandom_range(0, 29) == 0) ww = int'($urandom_range(0, 3));
    cyc("rand", nn, ww, $urandom_range(0, 11) == 0);
  endtask

  task automatic rdir(input bit dn, input int k, input int c);
    repeat (k) begin
      if (dn) rstep(c, 0); else rstep(0, c);
    end
  endtask

  initial begin
    reset_n = 1'b0; ns_i = RED; we_i = RED; clear_i = 1'b0;
    model_reset();
    #3;
    check_model("reset");
    #9 reset_n = 1'b1;

    legal_cycle("legal");
    check("legal.phase2", phase_count, 16'd2);
    check("legal.noerr", 16'(err_any), 16'd0);

    cyc("conflict", 2, 1, 1'b0);
    check("conflict.set", 16'(err_conflict), 16'd1);
    cyc("conflict_hold", 0, 0, 1'b0);
    check("conflict.sticky", 16'(err_conflict), 16'd1);
    cyc("conflict_clr", 0, 0, 1'b1);
    check("conflict.cleared", 16'(err_any), 16'd0);

    cyc("seq_jump", 0, 2, 1'b0);
    check("seq.set", 16'(err_sequence), 16'd1);
    run("seq_green", 14, 0, 2);
    run("seq_yellow", 1, 0, 1);
    run("seq_red", 1, 0, 0);
    check("seq.notiming", 16'(err_timing), 16'd0);
    check("seq.phase3", phase_count, 16'd3);
    cyc("seq_clr", 0, 0, 1'b1);

    run("ovr_y", 1, 0, 1);
    run("ovr_g16", 16, 0, 2);
    check("ovr.at16", 16'(err_timing), 16'd0);
    run("ovr_g17", 1, 0, 2);
    check("ovr.at17", 16'(err_timing), 16'd1);
    run("ovr_exit", 1, 0, 1);
    run("ovr_red", 1, 0, 0);
    cyc("ovr_clr", 0, 0, 1'b1);

    run("short_y", 1, 0, 1);
    run("short_g", 13, 0, 2);
    check("short.before", 16'(err_timing), 16'd0);
    run("short_exit", 1, 0, 1);
    check("short.on_yellow", 16'(err_timing), 16'd1);

    cyc("stall_1", 0, 0, 1'b1);
    run("stall_2_4", 3, 0, 0);
    check("stall.at4", 16'(err_stall), 16'd0);
    run("stall_5", 1, 0, 0);
    check("stall.at5", 16'(err_stall), 16'd1);
    cyc("stall_clr", 0, 0, 1'b1);
    check("stall.cleared", 16'(err_stall), 16'd0);

    cyc("simul_set", 1, 1, 1'b0);
    cyc("simul_clr", 1, 1, 1'b1);
    check("simul.setwins", 16'(err_conflict), 16'd1);
    cyc("reset_green", 0, 2, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("areset.any", 16'(err_any), 16'd0);
    check("areset.phase", phase_count, 16'd0);
    check_model("areset");
    #3 reset_n = 1'b1;
    legal_cycle("post_reset");
    check("post_reset.noerr", 16'(err_any), 16'd0);
    check("post_reset.phase2", phase_count, 16'd2);

    for (int p = 0; p < 24; p++) begin
      bit dn = p[0];
      rdir(dn, int'($urandom_range(1, 6)), 0);
      rdir(dn, int'($urandom_range(0, 5)), 1);
      rdir(dn, int'($urandom_range(12, 18)), 2);
      rdir(dn, int'($urandom_range(0, 5)), 1);
    end
    rdir(1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
